// File: rtl/ir_pulse_detector_pkg.sv
// pulse_pkg: shared types and constants for the IR pulse detector and its BPM divider.
package pulse_pkg;
   typedef enum logic [1:0] {INIT, RISING, FALLING} state_t;
   localparam int FS_HZ          = 500;
   localparam int DEF_BPM_NUM    = 60 * FS_HZ;
   localparam int DEF_MIN_PERIOD = 150;
   localparam int DEF_MAX_PERIOD = 1000;
   localparam int DIVD_W         = 15;
   localparam int DIVS_W         = 10;
   function automatic logic [7:0] sat8(input logic [DIVD_W-1:0] q);
      return |q[DIVD_W-1:8] ? 8'hFF : q[7:0];
   endfunction
endpackage

// File: rtl/ir_pulse_detector_if.sv
// ir_pulse_detector_if: filtered sample stream in, beat/rate results out.
interface ir_pulse_detector_if #(parameter int DATA_W = 20);
   logic [DATA_W-1:0] Sample_In;
   logic              Sample_Valid;
   logic              Beat_Pulse;
   logic [7:0]        BPM;
   logic              BPM_Valid;
   logic              Pulse_Lost;
   modport master (output Sample_In, Sample_Valid, input Beat_Pulse, BPM, BPM_Valid, Pulse_Lost);
   modport slave  (input Sample_In, Sample_Valid, output Beat_Pulse, BPM, BPM_Valid, Pulse_Lost);
endinterface

// File: rtl/ir_pulse_detector_bpm_divider.sv
// bpm_divider: serial restoring divider, one quotient bit per cycle; done pulses 15 cycles after the load.
module bpm_divider
   import pulse_pkg::*;
(
   input  logic              CLK_Filter,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIVD_W-1:0] dividend,
   input  logic [DIVS_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DIVD_W-1:0] quotient
);
   logic [DIVS_W-1:0] rem, div;
   logic [3:0]        cnt;
   logic [DIVS_W:0]   shifted;
   logic [DIVS_W+1:0] trial;
   assign shifted = {rem, quotient[DIVD_W-1]};
   assign trial   = {1'b0, shifted} - {2'b0, div};
   always_ff @(posedge CLK_Filter or negedge rst_n)
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         rem      <= '0;
         div      <= '0;
         cnt      <= '0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            rem      <= trial[DIVS_W+1] ? shifted[DIVS_W-1:0] : trial[DIVS_W-1:0];
            quotient <= {quotient[DIVD_W-2:0], ~trial[DIVS_W+1]};
            cnt      <= cnt + 4'd1;
            if (cnt == 4'(DIVD_W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else if (start) begin
            busy     <= 1'b1;
            rem      <= '0;
            div      <= divisor;
            cnt      <= '0;
            quotient <= dividend;
         end
      end
endmodule

// File: rtl/ir_pulse_detector.sv
// ir_pulse_detector: hysteresis peak finder, beat period counter and BPM output for the IR channel.
// Define PULSE_AVG_EN to derive BPM from the running average of the last 4 accepted periods.
module ir_pulse_detector
   import pulse_pkg::*;
#(
   parameter int DATA_W     = 20,
   parameter int HYST       = 4096,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int MAX_PERIOD = DEF_MAX_PERIOD,
   parameter int BPM_NUM    = DEF_BPM_NUM
) (
   input logic                CLK_Filter,
   input logic                rst_n,
   ir_pulse_detector_if.slave bus
);
   localparam int W = DATA_W + 1;
   state_t              state;
   logic [DATA_W-1:0]   run_max, run_min;
   logic [DIVS_W-1:0]   period_cnt, cnt_inc, divisor;
   logic                have_beat, peak, arm, accept, timeout, busy, done;
   logic [DIVD_W-1:0]   quotient;
   logic [W-1:0]        s_ext;
   assign s_ext   = {1'b0, bus.Sample_In};
   assign peak    = bus.Sample_Valid && state == RISING && s_ext + W'(HYST) <= {1'b0, run_max};
   assign cnt_inc = period_cnt == DIVS_W'(MAX_PERIOD) ? period_cnt : period_cnt + 1'b1;
   assign arm     = peak && !have_beat;
   assign accept  = peak && have_beat && cnt_inc >= DIVS_W'(MIN_PERIOD);
   // a peak landing on the saturating sample wins over the timeout
   assign timeout = bus.Sample_Valid && !arm && !accept && cnt_inc == DIVS_W'(MAX_PERIOD);
`ifdef PULSE_AVG_EN
   logic [DIVS_W-1:0]   hist [3];
   logic [2:0]          fill, fill_n;
   logic [DIVS_W+1:0]   sum, avg;
   always_comb begin
      fill_n = fill == 3'd4 ? fill : fill + 3'd1;
      sum    = {2'b0, cnt_inc} + {2'b0, hist[0]} + {2'b0, hist[1]} + {2'b0, hist[2]};
      case (fill_n)
         3'd1:    avg = sum;
         3'd2:    avg = sum >> 1;
         3'd3:    avg = sum / (DIVS_W+2)'(3);
         default: avg = sum >> 2;
      endcase
   end
   assign divisor = avg[DIVS_W-1:0];
   always_ff @(posedge CLK_Filter or negedge rst_n)
      if (!rst_n) begin
         hist <= '{default: '0};
         fill <= '0;
      end else if (accept) begin
         hist <= '{cnt_inc, hist[0], hist[1]};
         fill <= fill_n;
      end else if (timeout) begin
         hist <= '{default: '0};
         fill <= '0;
      end
`else
   assign divisor = cnt_inc;
`endif
   always_ff @(posedge CLK_Filter or negedge rst_n)
      if (!rst_n) begin
         state          <= INIT;
         run_max        <= '0;
         run_min        <= '1;
         period_cnt     <= '0;
         have_beat      <= 1'b0;
         bus.Beat_Pulse <= 1'b0;
         bus.BPM        <= '0;
         bus.BPM_Valid  <= 1'b0;
         bus.Pulse_Lost <= 1'b1;
      end else begin
         bus.Beat_Pulse <= accept;
         bus.BPM_Valid  <= done;
         if (done) bus.BPM <= sat8(quotient);
         else if (timeout) bus.BPM <= '0;
         if (bus.Sample_Valid) begin
            period_cnt <= (arm || accept) ? '0 : cnt_inc;
            case (state)
               INIT: begin
                  run_max <= bus.Sample_In;
                  run_min <= bus.Sample_In;
                  state   <= RISING;
               end
               RISING:
                  if (peak) begin
                     run_min <= bus.Sample_In;
                     state   <= FALLING;
                  end else if (bus.Sample_In > run_max) run_max <= bus.Sample_In;
               FALLING:
                  if (s_ext >= {1'b0, run_min} + W'(HYST)) begin
                     run_max <= bus.Sample_In;
                     state   <= RISING;
                  end else if (bus.Sample_In < run_min) run_min <= bus.Sample_In;
               default: state <= INIT;
            endcase
         end
         if (arm) have_beat <= 1'b1;
         else if (timeout) have_beat <= 1'b0;
         if (accept) bus.Pulse_Lost <= 1'b0;
         else if (timeout) bus.Pulse_Lost <= 1'b1;
      end
   bpm_divider u_div (
      .CLK_Filter (CLK_Filter),
      .rst_n      (rst_n),
      .start      (accept && !busy),
      .dividend   (DIVD_W'(BPM_NUM)),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient)
   );
endmodule
